// File: rtl/sort_in_if_pkg.sv
// Shared types and helpers for the sort-path ingress stage: FSM state encoding,
// default sizing and the ceil-log2 helper used to size buffer addresses.
package sort_in_if_pkg;

  localparam int unsigned DefDataWidth = 16;
  localparam int unsigned DefMaxLength = 256;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StWrData  = 3'd1,
    StSendReq = 3'd2,
    StWaitAck = 3'd3,
    StWaitRel = 3'd4
  } state_e;

  // Bits needed to address 'value' locations; never less than 1.
  function automatic int unsigned alt_clogb2(input int unsigned value);
    int unsigned res;
    int unsigned v;
    res = 0;
    v = (value > 0) ? value - 1 : 0;
    while (v > 0) begin
      res++;
      v = v >> 1;
    end
    return (res == 0) ? 1 : res;
  endfunction

endpackage

// File: rtl/sort_in_if_if.sv
// Stream, buffer-write and req/ack signals of the sort ingress stage.
// master = upstream source / read side, slave = the sort_in_if block.
interface sort_in_if_if #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] snk_data;
  logic                  snk_sop;
  logic                  snk_eop;
  logic                  snk_valid;
  logic                  snk_ready;
  logic [DATA_WIDTH-1:0] buf_data;
  logic [ADDR_WIDTH-1:0] buf_wraddress;
  logic                  buf_wren;
  logic                  snk_req;
  logic                  src_ack;
  logic [ADDR_WIDTH-1:0] tran_len;

  modport master (
    output snk_data, snk_sop, snk_eop, snk_valid, src_ack,
    input  snk_ready, buf_data, buf_wraddress, buf_wren, snk_req, tran_len
  );

  modport slave (
    input  snk_data, snk_sop, snk_eop, snk_valid, src_ack,
    output snk_ready, buf_data, buf_wraddress, buf_wren, snk_req, tran_len
  );
endinterface

// File: rtl/sort_sync2.sv
// Two-flop synchroniser with asynchronous active-low reset; resets to 0.
module sort_sync2 (
  input  logic clock,
  input  logic reset_n,
  input  logic d,
  output logic q
);
  logic [1:0] sync_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], d};
    end
  end

  assign q = sync_q[1];
endmodule

// File: rtl/sort_in_if.sv
// Sort-path ingress: writes one stream packet into the packet buffer from address 0, then
// hands it to the read side with a 4-phase req/ack. Optional stats: SORT_IN_IF_STAT_EN.
module sort_in_if
  import sort_in_if_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DefDataWidth,
  parameter int unsigned MAX_LENGTH = DefMaxLength
) (
  input  logic        snk_clock,
  input  logic        snk_reset_n,
  sort_in_if_if.slave bus
`ifdef SORT_IN_IF_STAT_EN
  ,
  output logic [15:0] pkt_cnt,
  output logic [7:0]  trunc_cnt,
  output logic [7:0]  drop_cnt
`endif
);
  localparam int unsigned ADDR_WIDTH = alt_clogb2(MAX_LENGTH);
  localparam logic [ADDR_WIDTH-1:0] LastAddr = ADDR_WIDTH'(MAX_LENGTH - 1);

  state_e                state_q, state_d;
  logic                  ready_q, ready_d;
  logic                  wren_q, wren_d;
  logic [ADDR_WIDTH-1:0] wraddr_q, wraddr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  req_q, req_d;
  logic [ADDR_WIDTH-1:0] tran_len_q, tran_len_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  ack_sync;
  logic                  accept;
  logic                  last_addr;

  sort_sync2 u_ack_sync (
    .clock   (snk_clock),
    .reset_n (snk_reset_n),
    .d       (bus.src_ack),
    .q       (ack_sync)
  );

  assign accept    = bus.snk_valid & ready_q;
  assign last_addr = (cnt_q == LastAddr);

  always_comb begin
    state_d    = state_q;
    wren_d     = 1'b0;
    wraddr_d   = wraddr_q;
    data_d     = data_q;
    req_d      = req_q;
    tran_len_d = tran_len_q;
    cnt_d      = cnt_q;

    unique case (state_q)
      StIdle, StWrData: begin
        if (accept) begin
          if (bus.snk_sop) begin
            // sop always (re)starts at address 0; a partial packet is simply abandoned
            wren_d   = 1'b1;
            wraddr_d = '0;
            data_d   = bus.snk_data;
            cnt_d    = ADDR_WIDTH'(1);
            if (bus.snk_eop) begin
              tran_len_d = '0;
              state_d    = StSendReq;
            end else begin
              state_d = StWrData;
            end
          end else if (state_q == StWrData) begin
            wren_d   = 1'b1;
            wraddr_d = cnt_q;
            data_d   = bus.snk_data;
            cnt_d    = cnt_q + ADDR_WIDTH'(1);
            // a full buffer closes the packet as if eop had been seen
            if (bus.snk_eop || last_addr) begin
              tran_len_d = cnt_q;
              state_d    = StSendReq;
            end
          end
        end
      end
      StSendReq: begin
        req_d   = 1'b1;
        state_d = StWaitAck;
      end
      StWaitAck: begin
        if (ack_sync) begin
          req_d   = 1'b0;
          state_d = StWaitRel;
        end
      end
      StWaitRel: begin
        if (!ack_sync) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    ready_d = (state_d == StIdle) || (state_d == StWrData);
  end

  always_ff @(posedge snk_clock or negedge snk_reset_n) begin
    if (!snk_reset_n) begin
      state_q    <= StIdle;
      ready_q    <= 1'b0;
      wren_q     <= 1'b0;
      wraddr_q   <= '0;
      data_q     <= '0;
      req_q      <= 1'b0;
      tran_len_q <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      ready_q    <= ready_d;
      wren_q     <= wren_d;
      wraddr_q   <= wraddr_d;
      data_q     <= data_d;
      req_q      <= req_d;
      tran_len_q <= tran_len_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bus.snk_ready     = ready_q;
  assign bus.buf_wren      = wren_q;
  assign bus.buf_wraddress = wraddr_q;
  assign bus.buf_data      = data_q;
  assign bus.snk_req       = req_q;
  assign bus.tran_len      = tran_len_q;

`ifdef SORT_IN_IF_STAT_EN
  logic        ev_pkt, ev_trunc, ev_drop;
  logic [15:0] pkt_q;
  logic [7:0]  trunc_q, drop_q;

  // StSendReq lasts exactly one cycle, so this fires once per published packet
  assign ev_pkt   = (state_d == StSendReq);
  assign ev_trunc = (state_q == StWrData) && accept && !bus.snk_sop && !bus.snk_eop &&
                    last_addr;
  assign ev_drop  = accept && (((state_q == StIdle) && !bus.snk_sop) ||
                               ((state_q == StWrData) && bus.snk_sop));

  always_ff @(posedge snk_clock or negedge snk_reset_n) begin
    if (!snk_reset_n) begin
      pkt_q   <= '0;
      trunc_q <= '0;
      drop_q  <= '0;
    end else begin
      if (ev_pkt && (pkt_q != '1)) pkt_q <= pkt_q + 16'd1;
      if (ev_trunc && (trunc_q != '1)) trunc_q <= trunc_q + 8'd1;
      if (ev_drop && (drop_q != '1)) drop_q <= drop_q + 8'd1;
    end
  end

  assign pkt_cnt   = pkt_q;
  assign trunc_cnt = trunc_q;
  assign drop_cnt  = drop_q;
`endif

endmodule

// File: tb/tb_sort_in_if.sv
// Randomised bench for sort_in_if against a packet-level reference model of the ingress stage.
module tb_sort_in_if;
  import sort_in_if_pkg::*;

  localparam int unsigned DW = 16;
  localparam int unsigned ML = 256;
  localparam int unsigned AW = alt_clogb2(ML);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sort_in_if_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

`ifdef SORT_IN_IF_STAT_EN
  logic [15:0] pkt_cnt;
  logic [7:0]  trunc_cnt;
  logic [7:0]  drop_cnt;
`endif

  sort_in_if #(.DATA_WIDTH(DW), .MAX_LENGTH(ML)) dut (
    .snk_clock   (clk),
    .snk_reset_n (rst_n),
    .bus         (bus)
`ifdef SORT_IN_IF_STAT_EN
    ,
    .pkt_cnt     (pkt_cnt),
    .trunc_cnt   (trunc_cnt),
    .drop_cnt    (drop_cnt)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;

  // Buffer image as seen through the write port
  logic [DW-1:0] mem [ML];
  int wr_cnt = 0;
  always @(posedge clk) begin
    if (bus.buf_wren) begin
      mem[bus.buf_wraddress] <= bus.buf_data;
      wr_cnt <= wr_cnt + 1;
    end
  end

  // Reference model: packet under construction, last completed packet, statistics
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] done_q[$];
  bit active = 0;
  int m_pkt = 0, m_trunc = 0, m_drop = 0, m_writes = 0;
  bit rst_in_hs = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_word(input logic [DW-1:0] d, input bit sop, input bit eop,
                            output bit done);
    done = 0;
    if (sop) begin
      if (active) m_drop++;
      exp_q.delete();
      exp_q.push_back(d);
      m_writes++;
      active = 1;
    end else if (active) begin
      exp_q.push_back(d);
      m_writes++;
    end else begin
      m_drop++;
      return;
    end
    if (eop || exp_q.size() == ML) begin
      if (!eop) m_trunc++;
      m_pkt++;
      done_q = exp_q;
      active = 0;
      done = 1;
    end
  endtask

  // Entered just after the clock edge that accepted the closing word
  task automatic handshake();
    int n;
    int bad;
    @(negedge clk);
    check_val("req_early", 32'(bus.snk_req), 0);
    check_val("rdy_drop", 32'(bus.snk_ready), 0);
    @(negedge clk);
    check_val("req_rise", 32'(bus.snk_req), 1);
    n = done_q.size();
    check_val("tran_len", 32'(bus.tran_len), n - 1);
    bad = 0;
    for (int i = 0; i < n; i++) if (mem[i] !== done_q[i]) bad++;
    check_val("buf_words_bad", bad, 0);
    if (rst_in_hs) begin
      #2 rst_n = 1'b0;
      #1;
      check_val("rst_req", 32'(bus.snk_req), 0);
      check_val("rst_rdy", 32'(bus.snk_ready), 0);
      check_val("rst_tlen", 32'(bus.tran_len), 0);
      active = 0;
      exp_q.delete();
      m_pkt = 0; m_trunc = 0; m_drop = 0;
      @(posedge clk);
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check_val("rst_rdy_back", 32'(bus.snk_ready), 1);
      @(posedge clk);
      #1;
    end else begin
      @(posedge clk);
      #1;
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      bus.src_ack = 1'b1;
      repeat (3) @(negedge clk);
      check_val("req_hold", 32'(bus.snk_req), 1);
      @(negedge clk);
      check_val("req_fall", 32'(bus.snk_req), 0);
      @(posedge clk);
      #1;
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      bus.src_ack = 1'b0;
      repeat (3) @(negedge clk);
      check_val("rdy_wait", 32'(bus.snk_ready), 0);
      @(negedge clk);
      check_val("rdy_back", 32'(bus.snk_ready), 1);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_word(input logic [DW-1:0] d, input bit sop, input bit eop, input int gap);
    bit acc;
    bit done;
    int tries;
    repeat (gap) begin
      bus.snk_valid = 1'b0;
      bus.snk_data  = DW'($urandom);
      bus.snk_sop   = 1'($urandom);
      bus.snk_eop   = 1'($urandom);
      @(posedge clk);
      #1;
    end
    bus.snk_data  = d;
    bus.snk_sop   = sop;
    bus.snk_eop   = eop;
    bus.snk_valid = 1'b1;
    acc = 0;
    tries = 0;
    while (!acc && tries < 50) begin
      @(negedge clk);
      acc = bus.snk_ready;
      @(posedge clk);
      #1;
      tries++;
    end
    bus.snk_valid = 1'b0;
    if (!acc) begin
      check_val("accept_timeout", 0, 1);
      return;
    end
    model_word(d, sop, eop, done);
    if (done) handshake();
  endtask

  task automatic send_pkt(input int len, input int gap_max, input bit eop_last);
    for (int i = 0; i < len; i++)
      send_word(DW'($urandom), (i == 0), eop_last && (i == len - 1),
                $urandom_range(0, gap_max));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.snk_data  = '0;
    bus.snk_sop   = 1'b0;
    bus.snk_eop   = 1'b0;
    bus.snk_valid = 1'b0;
    bus.src_ack   = 1'b0;
    #12;
    check_val("rst_ready", 32'(bus.snk_ready), 0);
    check_val("rst_req0", 32'(bus.snk_req), 0);
    check_val("rst_wren", 32'(bus.buf_wren), 0);
    check_val("rst_wraddr", 32'(bus.buf_wraddress), 0);
    check_val("rst_bdata", 32'(bus.buf_data), 0);
    check_val("rst_tlen0", 32'(bus.tran_len), 0);
`ifdef SORT_IN_IF_STAT_EN
    check_val("rst_pkt_cnt", 32'(pkt_cnt), 0);
    check_val("rst_drop_cnt", 32'(drop_cnt), 0);
`endif
    @(posedge clk);
    #1 rst_n = 1'b1;

    send_pkt(4, 0, 1);                          // basic 4-word packet
    send_word(16'hA5A5, 1, 1, 0);               // single word sop&eop
    send_pkt(300, 0, 1);                        // overflow: 256 kept, 44 dropped
`ifdef SORT_IN_IF_STAT_EN
    check_val("ovf_trunc_cnt", 32'(trunc_cnt), sat(m_trunc, 255));
    check_val("ovf_drop_cnt", 32'(drop_cnt), sat(m_drop, 255));
`endif
    send_pkt(10, 0, 0);                         // abandoned partial packet
    send_pkt(3, 0, 1);
    for (int i = 0; i < 6; i++)                 // valid toggling 1010...
      send_word(DW'($urandom), (i == 0), (i == 5), (i == 0) ? 0 : 1);
    rst_in_hs = 1;                              // reset while waiting for ack
    send_pkt(5, 0, 1);
    rst_in_hs = 0;
    send_pkt(3, 1, 1);

    for (int p = 0; p < 25; p++) begin
      repeat ($urandom_range(0, 2)) send_word(DW'($urandom), 0, 1'($urandom), 1);
      if ($urandom_range(0, 4) == 0) send_pkt($urandom_range(1, 12), 2, 0);
      send_pkt($urandom_range(1, 24), 2, 1);
    end

    repeat (3) @(posedge clk);
    #1;
    check_val("write_total", wr_cnt, m_writes);
`ifdef SORT_IN_IF_STAT_EN
    check_val("pkt_cnt", 32'(pkt_cnt), sat(m_pkt, 65535));
    check_val("trunc_cnt", 32'(trunc_cnt), sat(m_trunc, 255));
    check_val("drop_cnt", 32'(drop_cnt), sat(m_drop, 255));
`endif
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
